// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: EX-stage ALU with iterative signed/unsigned mul/div into HI/LO
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [1:0]         aluopcode,
  input  logic [5:0]         func,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal,
  output logic               stall,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic rtype, md_f, mf_f, start, last, sa, sb, is_div, neg_q, neg_r, dz, bad;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] m, abs_a, abs_b, q_fix, r_fix;
  logic [2*WIDTH-1:0] p, p_nx, prod_fix;
  logic [WIDTH:0] acc, r_sh, diff;
  assign rtype = aluopcode == 2'b10;
  assign md_f = rtype & (func[5:2] == 4'b0110);
  assign mf_f = rtype & (func == 6'b010000 | func == 6'b010010);
  assign busy = state == RUN;
  assign start = in_valid & md_f & ~busy;
  assign stall = in_valid & busy & (md_f | mf_f);
  assign last = cnt == '0;
  assign sa = ~func[0] & a[WIDTH-1];
  assign sb = ~func[0] & b[WIDTH-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;
  assign acc = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
  assign r_sh = p[2*WIDTH-1:WIDTH-1];
  assign diff = r_sh - {1'b0, m};
  assign p_nx = !is_div ? {acc, p[WIDTH-1:1]} :
                diff[WIDTH] ? {p[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  assign prod_fix = neg_q ? -p_nx : p_nx;
  assign q_fix = dz ? '1 : neg_q ? -p_nx[WIDTH-1:0] : p_nx[WIDTH-1:0];
  assign r_fix = neg_r ? -p_nx[2*WIDTH-1:WIDTH] : p_nx[2*WIDTH-1:WIDTH];
  // mul/div sequencer state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // accept in IDLE, return to IDLE after the final iteration
  always_comb begin
    state_nx = start ? RUN : (busy & last) ? IDLE : state;
  end
  // operand latch, one shift-add / restoring-subtract step per cycle, HI/LO writeback
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p <= '0;
      m <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (start) begin
      p <= {{WIDTH{1'b0}}, abs_a};
      m <= abs_b;
      cnt <= CNT_W'(WIDTH-1);
      is_div <= func[1];
      neg_q <= sa ^ sb;
      neg_r <= sa;
      dz <= func[1] & (b == '0);
    end else if (busy) begin
      p <= p_nx;
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        hi <= is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo <= is_div ? q_fix : prod_fix[WIDTH-1:0];
      end
    end
  // single-cycle result and decode of illegal encodings
  always_comb begin
    result = '0;
    bad = 1'b0;
    if (aluopcode == 2'b00) result = a + b;
    else if (aluopcode == 2'b01) result = a - b;
    else if (aluopcode == 2'b11) bad = 1'b1;
    else
      case (func)
        6'b100000, 6'b100001: result = a + b;
        6'b100010, 6'b100011: result = a - b;
        6'b100100: result = a & b;
        6'b100101: result = a | b;
        6'b100110: result = a ^ b;
        6'b100111: result = ~(a | b);
        6'b101010: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        6'b101011: result = {{(WIDTH-1){1'b0}}, a < b};
        6'b000000: result = b << shamt;
        6'b000010: result = b >> shamt;
        6'b000011: result = WIDTH'($signed(b) >>> shamt);
        6'b010000: result = hi;
        6'b010010: result = lo;
        6'b011000, 6'b011001, 6'b011010, 6'b011011: result = '0;
        default: bad = 1'b1;
      endcase
  end
  assign illegal = in_valid & bad;
  assign zero = result == '0;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: directed scoreboard bench for alu_muldiv_unit
module tb_alu_muldiv_unit;
  logic clk, rst_n, in_valid, zero, illegal, stall, busy;
  logic [1:0] aluopcode;
  logic [5:0] func;
  logic [4:0] shamt;
  logic [31:0] a, b, result, hi, lo;
  int n_checks = 0, n_fail = 0, cyc;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t sb[$];
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                         F_DIVU = 6'b011011, F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  alu_muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .aluopcode(aluopcode), .func(func),
    .shamt(shamt), .a(a), .b(b), .result(result), .zero(zero), .illegal(illegal),
    .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.v);
    end
  endtask
  function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    logic [63:0] pr;
    pr = '0;
    h = '0;
    l = '0;
    if (f == F_MULT || f == F_MULTU) begin
      pr = (f == F_MULT) ? $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y})
                         : {32'b0, x} * {32'b0, y};
      h = pr[63:32];
      l = pr[31:0];
    end else if (y == 0) begin
      l = '1;
      h = x;
    end else if (f == F_DIV && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
      l = 32'h80000000;
      h = 0;
    end else if (f == F_DIV) begin
      l = $signed(x) / $signed(y);
      h = $signed(x) % $signed(y);
    end else begin
      l = x / y;
      h = x % y;
    end
  endfunction
  task automatic alu(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                     input logic [31:0] y, input logic [4:0] sh, input logic [31:0] exp,
                     input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    aluopcode = op;
    func = f;
    a = x;
    b = y;
    shamt = sh;
    push(tag, exp);
    #1;
    pop_chk(result);
  endtask
  task automatic issue_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          input string tag);
    logic [31:0] h, l;
    @(negedge clk);
    in_valid = 1'b1;
    aluopcode = 2'b10;
    func = f;
    a = x;
    b = y;
    model(f, x, y, h, l);
    push({tag, "_hi"}, h);
    push({tag, "_lo"}, l);
    push({tag, "_mfhi"}, h);
    push({tag, "_mflo"}, l);
    #1;
    chk({tag, "_issue_stall"}, {31'b0, stall}, 0);
    cyc = 0;
  endtask
  task automatic wait_done(input string tag);
    int guard = 0;
    while (guard < 100) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (!busy) break;
      cyc++;
      guard++;
    end
    chk({tag, "_busy_cycles"}, cyc, 32);
    pop_chk(hi);
    pop_chk(lo);
    in_valid = 1'b1;
    aluopcode = 2'b10;
    func = F_MFHI;
    #1;
    pop_chk(result);
    func = F_MFLO;
    #1;
    pop_chk(result);
    in_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    aluopcode = 2'b00;
    func = '0;
    shamt = '0;
    a = '0;
    b = '0;
    @(negedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst_n = 1'b1;
    alu(2'b10, 6'b100111, 32'h0F0F0000, 32'h00F0000F, 0, 32'hF000FFF0, "nor");
    chk("nor_zero", {31'b0, zero}, 0);
    chk("nor_illegal", {31'b0, illegal}, 0);
    alu(2'b10, 6'b000011, 0, 32'h80000000, 4, 32'hF8000000, "sra");
    alu(2'b10, 6'b000010, 0, 32'h80000000, 4, 32'h08000000, "srl");
    alu(2'b10, 6'b000000, 0, 32'h80000001, 31, 32'h80000000, "sll");
    alu(2'b10, 6'b101011, 1, 32'hFFFFFFFF, 0, 1, "sltu");
    alu(2'b10, 6'b101010, 1, 32'hFFFFFFFF, 0, 0, "slt");
    alu(2'b10, 6'b100110, 32'hFF00FF00, 32'h0FF00FF0, 0, 32'hF0F0F0F0, "xor");
    alu(2'b00, 6'b000000, 5, 32'hFFFFFFFB, 0, 0, "add_wrap");
    chk("add_zero", {31'b0, zero}, 1);
    alu(2'b01, 6'b000000, 0, 1, 0, 32'hFFFFFFFF, "sub_op");
    alu(2'b11, 6'b100000, 3, 4, 0, 0, "rsvd_result");
    chk("rsvd_illegal", {31'b0, illegal}, 1);
    alu(2'b10, 6'b111111, 3, 4, 0, 0, "badfunc_result");
    chk("badfunc_illegal", {31'b0, illegal}, 1);
    alu(2'b00, F_MULT, 6, 7, 0, 13, "op00_mult_add");
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("op00_no_start", {31'b0, busy}, 0);
    issue_md(F_MULT, 32'hFFFFFFFD, 7, "mult");
    @(negedge clk);
    in_valid = 1'b1;
    func = F_MFLO;
    #1;
    if (busy) cyc++;
    chk("mflo_busy_stall", {31'b0, stall}, 1);
    chk("mflo_busy_old_lo", result, 0);
    @(negedge clk);
    func = 6'b100001;
    a = 10;
    b = 20;
    #1;
    if (busy) cyc++;
    chk("add_busy_stall", {31'b0, stall}, 0);
    chk("add_busy_result", result, 30);
    wait_done("mult");
    issue_md(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
    wait_done("multu");
    issue_md(F_DIV, 32'hFFFFFFF9, 2, "div");
    wait_done("div");
    issue_md(F_DIV, 32'h80000000, 32'hFFFFFFFF, "div_min");
    wait_done("div_min");
    issue_md(F_DIVU, 32'hDEADBEEF, 1234, "divu");
    wait_done("divu");
    issue_md(F_DIV, 32'hFFFFFF00, 0, "div_zero");
    wait_done("div_zero");
    issue_md(F_DIVU, 5, 0, "divu_zero");
    wait_done("divu_zero");
    issue_md(F_MULTU, 32'h12345678, 9, "abort");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue_md(F_MULT, 123456, 32'hFFFFFCEB, "post_rst");
    wait_done("post_rst");
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
